// File: rtl/cpu_pkg.sv
// Shared types and constants for the single-cycle RV32I-subset core:
// opcodes, funct fields, ALU/immediate/writeback selectors, decoded control word.
package cpu_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 value selecting SUB / SRA / SRAI (only bit 30 of the instruction differs)
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     branch;
    logic     jal;
    logic     jalr;
    logic     b_imm;      // operand B is the immediate instead of rs2
    a_sel_t   a_sel;
    alu_op_t  alu_op;
    imm_sel_t imm_sel;
    wb_sel_t  wb_sel;
  } ctrl_t;

  // Sign-extended immediate for each instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_t sel);
    case (sel)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // ALU operation from funct3 and the alternate bit; SUB exists only for R-type.
  function automatic alu_op_t decode_alu(input logic [2:0] f3, input logic alt,
                                         input logic is_reg);
    case (f3)
      F3_ADD_SUB: return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/single_cycle_cpu_if.sv
// Data-memory bus between the core datapath (master) and the data memory (slave).
interface single_cycle_cpu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/single_cycle_cpu_data_memory.sv
// Word-addressed data memory: combinational read, write on rising clk.
// Byte address bits [1:0] are ignored; the word index wraps modulo DEPTH (power of 2).
module data_memory #(
  parameter int DEPTH = 256
) (
  input logic               clk,
  single_cycle_cpu_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram_memory [0:DEPTH-1];
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  assign word_idx         = bus.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};
  assign bus.rdata        = ram_memory[word_idx];

  // Store port.
  always_ff @(posedge clk) begin
    if (bus.we) ram_memory[word_idx] <= bus.wdata;
  end

endmodule

// File: rtl/single_cycle_cpu_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// x0 is hard-wired to zero on read and is never written.
module reg_file (
  input  logic        clk,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        reg_write_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);

  logic [31:0] register_memory [0:31];

  // Write port.
  // NOTE: storage arrays get no reset so preloaded contents survive rst; sequential
  // state always uses non-blocking (<=) so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reg_write_i && (rd_addr_i != 5'd0)) register_memory[rd_addr_i] <= rd_data_i;
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : register_memory[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : register_memory[rs2_addr_i];

endmodule

// File: rtl/single_cycle_cpu.sv
// RV32I-subset single-cycle core: one instruction retires per rising clk edge.
// Optional macro CPU_TRACE_EN prints one trace line per retired instruction.
// rst is asynchronous and active-low; only the PC is reset.
module single_cycle_cpu
  import cpu_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter string       IMEM_INIT  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst
);

  localparam int IAW = $clog2(IMEM_DEPTH);

  logic [31:0] imem_mem [0:IMEM_DEPTH-1];
  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr, imm;
  logic [31:0] rs1_data, rs2_data, alu_a, alu_b, alu_result, rd_data;
  logic        br_taken, reg_we;
  ctrl_t       ctrl;

  single_cycle_cpu_if dmem_bus ();

  assign instr    = imem_mem[pc_q[IAW+1:2]];
  assign imm      = imm_gen(instr, ctrl.imm_sel);
  assign pc_plus4 = pc_q + 32'd4;

  // Main decoder.
  // NOTE: ctrl gets a full default first so no path through the case infers a latch.
  always_comb begin
    ctrl = '0;
    case (instr[6:0])
      OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = decode_alu(instr[14:12], instr[30], 1'b1);
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.alu_op    = decode_alu(instr[14:12], instr[30], 1'b0);
      end
      LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.wb_sel    = WB_MEM;
      end
      STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.imm_sel   = IMM_S;
      end
      BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_sel = IMM_B;
      end
      JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.imm_sel   = IMM_J;
        ctrl.wb_sel    = WB_PC4;
      end
      JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.a_sel     = A_ZERO;
        ctrl.imm_sel   = IMM_U;
      end
      AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.b_imm     = 1'b1;
        ctrl.a_sel     = A_PC;
        ctrl.imm_sel   = IMM_U;
      end
      default: ;  // unknown opcode: NOP
    endcase
  end

  // Writes are suppressed while rst is held so nothing retires during reset.
  assign reg_we = ctrl.reg_write & rst;

  reg_file reg_file_inst (
    .clk        (clk),
    .rs1_addr_i (instr[19:15]),
    .rs2_addr_i (instr[24:20]),
    .rd_addr_i  (instr[11:7]),
    .rd_data_i  (rd_data),
    .reg_write_i(reg_we),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data)
  );

  // ALU operand selection.
  always_comb begin
    alu_b = ctrl.b_imm ? imm : rs2_data;
    case (ctrl.a_sel)
      A_PC:    alu_a = pc_q;
      A_ZERO:  alu_a = 32'd0;
      default: alu_a = rs1_data;
    endcase
  end

  // ALU.
  always_comb begin
    case (ctrl.alu_op)
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLL:  alu_result = alu_a << alu_b[4:0];
      ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
      default:  alu_result = alu_a + alu_b;
    endcase
  end

  // Branch condition on the two register operands.
  always_comb begin
    case (instr[14:12])
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data < rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  assign dmem_bus.addr  = alu_result;
  assign dmem_bus.wdata = rs2_data;
  assign dmem_bus.we    = ctrl.mem_write & rst;

  data_memory #(.DEPTH(DMEM_DEPTH)) data_memory_inst (
    .clk(clk),
    .bus(dmem_bus)
  );

  // Writeback source.
  always_comb begin
    case (ctrl.wb_sel)
      WB_MEM:  rd_data = dmem_bus.rdata;
      WB_PC4:  rd_data = pc_plus4;
      default: rd_data = alu_result;
    endcase
  end

  // Next-PC selection.
  always_comb begin
    pc_d = pc_plus4;
    if (ctrl.jal)                     pc_d = pc_q + imm;
    else if (ctrl.jalr)               pc_d = alu_result & ~32'd1;
    else if (ctrl.branch && br_taken) pc_d = pc_q + imm;
  end

  // Program counter, the only reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

`ifdef CPU_TRACE_EN
  // Trace of each retiring instruction.
  always @(posedge clk) begin
    if (rst) begin
      if (reg_we && (instr[11:7] != 5'd0))
        $display("[trace] pc=%08h instr=%08h rd=x%0d wdata=%08h", pc_q, instr, instr[11:7], rd_data);
      else if (dmem_bus.we)
        $display("[trace] pc=%08h instr=%08h st addr=%08h data=%08h", pc_q, instr, dmem_bus.addr, dmem_bus.wdata);
      else
        $display("[trace] pc=%08h instr=%08h", pc_q, instr);
    end
  end
`endif

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed self-checking bench for single_cycle_cpu: preloads registers and a
// hand-assembled program, then checks architectural state after fixed cycle counts.
module tb_single_cycle_cpu;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  single_cycle_cpu #(
    .IMEM_DEPTH(256),
    .DMEM_DEPTH(256),
    .IMEM_INIT (""),
    .RESET_PC  (32'h0)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  localparam logic [6:0] O_R = 7'b0110011, O_I = 7'b0010011, O_LD = 7'b0000011;
  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JALR = 7'b1100111;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, O_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Program image; unlisted words stay zero (unknown opcode -> NOP).
    for (int i = 0; i < 256; i++) dut.imem_mem[i] = 32'h0;
    dut.imem_mem[0]  = enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd3);      // add  x3,x1,x0
    dut.imem_mem[1]  = enc_r(7'h20, 5'd4, 5'd1, 3'd0, 5'd5);      // sub  x5,x1,x4
    dut.imem_mem[2]  = enc_i(32'd60, 5'd0, 3'd0, 5'd9, O_I);      // addi x9,x0,60
    dut.imem_mem[3]  = enc_s(32'd4, 5'd5, 5'd6);                  // sw   x5,4(x6)
    dut.imem_mem[4]  = enc_i(32'd4, 5'd6, 3'd2, 5'd7, O_LD);      // lw   x7,4(x6)
    dut.imem_mem[5]  = enc_i(32'd5, 5'd0, 3'd0, 5'd1, O_I);       // addi x1,x0,5
    dut.imem_mem[6]  = enc_i(32'd5, 5'd0, 3'd0, 5'd2, O_I);       // addi x2,x0,5
    dut.imem_mem[7]  = enc_b(32'd8, 5'd2, 5'd1, 3'd0);            // beq  x1,x2,+8
    dut.imem_mem[8]  = enc_i(32'd1, 5'd0, 3'd0, 5'd3, O_I);       // addi x3,x0,1
    dut.imem_mem[9]  = enc_i(32'd200, 5'd0, 3'd0, 5'd4, O_I);     // addi x4,x0,200
    dut.imem_mem[10] = enc_i(32'd10, 5'd0, 3'd0, 5'd1, O_I);      // addi x1,x0,10
    dut.imem_mem[11] = enc_j(32'd8, 5'd3);                        // jal  x3,+8
    dut.imem_mem[12] = enc_i(32'd1, 5'd0, 3'd0, 5'd2, O_I);       // addi x2,x0,1
    dut.imem_mem[13] = enc_i(32'd20, 5'd0, 3'd0, 5'd2, O_I);      // addi x2,x0,20
    dut.imem_mem[14] = enc_i(32'd99, 5'd0, 3'd0, 5'd5, O_I);      // addi x5,x0,99
    dut.imem_mem[15] = enc_i(32'd7, 5'd0, 3'd0, 5'd0, O_I);       // addi x0,x0,7
    dut.imem_mem[16] = {20'h12345, 5'd10, O_LUI};                 // lui  x10,0x12345
    dut.imem_mem[17] = {20'h00001, 5'd11, O_AUIPC};               // auipc x11,1
    dut.imem_mem[18] = enc_i(32'hFFFF_FFFF, 5'd0, 3'd0, 5'd12, O_I); // addi x12,x0,-1
    dut.imem_mem[19] = enc_b(32'd8, 5'd2, 5'd1, 3'd1);            // bne  x1,x2  taken
    dut.imem_mem[20] = enc_i(32'd1, 5'd0, 3'd0, 5'd13, O_I);      // addi x13,x0,1 (skipped)
    dut.imem_mem[21] = enc_b(32'd8, 5'd1, 5'd1, 3'd1);            // bne  x1,x1  not taken
    dut.imem_mem[22] = enc_b(32'd8, 5'd1, 5'd12, 3'd4);           // blt  x12,x1 taken
    dut.imem_mem[23] = enc_i(32'd2, 5'd0, 3'd0, 5'd13, O_I);      // (skipped)
    dut.imem_mem[24] = enc_b(32'd8, 5'd12, 5'd1, 3'd4);           // blt  x1,x12 not taken
    dut.imem_mem[25] = enc_b(32'd8, 5'd1, 5'd12, 3'd7);           // bgeu x12,x1 taken
    dut.imem_mem[26] = enc_i(32'd3, 5'd0, 3'd0, 5'd13, O_I);      // (skipped)
    dut.imem_mem[27] = enc_b(32'd8, 5'd12, 5'd1, 3'd7);           // bgeu x1,x12 not taken
    dut.imem_mem[28] = enc_i(32'd129, 5'd0, 3'd0, 5'd14, O_I);    // addi x14,x0,129
    dut.imem_mem[29] = enc_i(32'd0, 5'd14, 3'd0, 5'd15, O_JALR);  // jalr x15,0(x14) -> 128
    dut.imem_mem[30] = enc_i(32'd4, 5'd0, 3'd0, 5'd13, O_I);      // (skipped)
    dut.imem_mem[31] = enc_i(32'd5, 5'd0, 3'd0, 5'd13, O_I);      // (skipped)
    dut.imem_mem[32] = enc_i(32'd7, 5'd0, 3'd0, 5'd16, O_I);      // addi x16,x0,7
    dut.imem_mem[33] = enc_i(32'd4, 5'd10, 3'd5, 5'd17, O_I);     // srli x17,x10,4
    dut.imem_mem[34] = enc_r(7'h00, 5'd12, 5'd1, 3'd3, 5'd18);    // sltu x18,x1,x12
    dut.imem_mem[35] = enc_r(7'h00, 5'd12, 5'd1, 3'd2, 5'd19);    // slt  x19,x1,x12
    dut.imem_mem[36] = enc_r(7'h00, 5'd12, 5'd10, 3'd4, 5'd20);   // xor  x20,x10,x12
    dut.imem_mem[37] = enc_j(32'd0, 5'd0);                        // jal  x0,0 (park)

    dut.reg_file_inst.register_memory[0]  = 32'd0;
    dut.reg_file_inst.register_memory[1]  = 32'd10;
    dut.reg_file_inst.register_memory[3]  = 32'd0;
    dut.reg_file_inst.register_memory[4]  = 32'd5;
    dut.reg_file_inst.register_memory[6]  = 32'd4;
    dut.reg_file_inst.register_memory[13] = 32'd0;

    // Reset held for two cycles: PC pinned, nothing retires.
    run_cycles(2);
    check("reset_pc", dut.pc_q, 32'h0);
    check("reset_no_wb_x3", dut.reg_file_inst.register_memory[3], 32'd0);
    @(negedge clk) rst = 1'b1;

    run_cycles(5);
    check("x3_add", dut.reg_file_inst.register_memory[3], 32'd10);
    check("x5_sub", dut.reg_file_inst.register_memory[5], 32'd5);
    check("x9_addi", dut.reg_file_inst.register_memory[9], 32'd60);
    check("ram2_sw", dut.data_memory_inst.ram_memory[2], 32'd5);
    check("x7_lw", dut.reg_file_inst.register_memory[7], 32'd5);
    check("pc_after5", dut.pc_q, 32'd20);

    run_cycles(4);
    check("x1_eq5", dut.reg_file_inst.register_memory[1], 32'd5);
    check("x2_eq5", dut.reg_file_inst.register_memory[2], 32'd5);
    check("x4_200", dut.reg_file_inst.register_memory[4], 32'd200);
    check("x3_beq_skip", dut.reg_file_inst.register_memory[3], 32'd10);
    check("pc_after9", dut.pc_q, 32'd40);

    run_cycles(4);
    check("x1_eq10", dut.reg_file_inst.register_memory[1], 32'd10);
    check("x3_jal_link", dut.reg_file_inst.register_memory[3], 32'd48);
    check("x2_jal_skip", dut.reg_file_inst.register_memory[2], 32'd20);
    check("x5_99", dut.reg_file_inst.register_memory[5], 32'd99);
    check("pc_after13", dut.pc_q, 32'd60);

    // 17 more instructions reach the parking jal at 148; extra cycles stay there.
    run_cycles(20);
    check("x0_store_unwritten", dut.reg_file_inst.register_memory[0], 32'd0);
    check("x12_reads_x0_zero", dut.reg_file_inst.register_memory[12], 32'hFFFF_FFFF);
    check("x10_lui", dut.reg_file_inst.register_memory[10], 32'h1234_5000);
    check("x11_auipc", dut.reg_file_inst.register_memory[11], 32'h0000_1044);
    check("x13_branches_skipped", dut.reg_file_inst.register_memory[13], 32'd0);
    check("x14_addi", dut.reg_file_inst.register_memory[14], 32'd129);
    check("x15_jalr_link", dut.reg_file_inst.register_memory[15], 32'd120);
    check("x16_jalr_target", dut.reg_file_inst.register_memory[16], 32'd7);
    check("x17_srli", dut.reg_file_inst.register_memory[17], 32'h0123_4500);
    check("x18_sltu", dut.reg_file_inst.register_memory[18], 32'd1);
    check("x19_slt", dut.reg_file_inst.register_memory[19], 32'd0);
    check("x20_xor", dut.reg_file_inst.register_memory[20], 32'hEDCB_AFFF);
    check("pc_parked", dut.pc_q, 32'd148);

    // Asynchronous reset in the middle of a cycle.
    rst = 1'b0;
    #1;
    check("async_reset_pc", dut.pc_q, 32'h0);
    check("reset_keeps_x10", dut.reg_file_inst.register_memory[10], 32'h1234_5000);
    check("reset_keeps_ram2", dut.data_memory_inst.ram_memory[2], 32'd5);
    run_cycles(1);
    check("reset_blocks_wb_x3", dut.reg_file_inst.register_memory[3], 32'd48);
    @(negedge clk) rst = 1'b1;
    run_cycles(1);
    check("restart_x3", dut.reg_file_inst.register_memory[3], 32'd10);
    check("restart_pc", dut.pc_q, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
